// File: rtl/dmem_pkg.sv
// ---------------------------------------------------------------------------
// dmem_pkg
// Shared definitions for the dual-port data-memory responder:
//   - default word-address and data widths
//   - responder state encoding (INIT sweep, RUN)
//   - classification of same-cycle A/B address hazards
//   - helper that classifies a hazard from the two accepted requests
// Optional feature macro used by the responder: DMEM_STATS_EN.
// ---------------------------------------------------------------------------
package dmem_pkg;

    localparam int ADDR_W_DEFAULT = 12;
    localparam int DATA_W_DEFAULT = 32;

    typedef enum logic {
        INIT,
        RUN
    } state_t;

    // Same-address interaction between slot A (older) and slot B (younger).
    typedef enum logic [2:0] {
        NONE,     // different addresses, or at most one slot active
        WW,       // both write: B's data is stored
        WR_FWD,   // A writes, B reads: B sees A's data
        RW_OLD,   // B writes, A reads: A sees the old contents
        RR        // both read the stored word
    } hazard_t;

    function automatic hazard_t classify_hazard(
        input logic same_addr,
        input logic acc_a,
        input logic acc_b,
        input logic wren_a,
        input logic wren_b
    );
        if (!(same_addr && acc_a && acc_b)) return NONE;
        if (wren_a && wren_b)               return WW;
        if (wren_a)                         return WR_FWD;
        if (wren_b)                         return RW_OLD;
        return RR;
    endfunction

endpackage

// File: rtl/dmem_bank.sv
// ---------------------------------------------------------------------------
// dmem_bank
// Two-write / two-read synchronous storage array. Reads return the contents
// before this edge's writes (read-before-write). When both ports write the
// same word, port B's data is kept.
// Ports:
//   clock              rising-edge clock
//   reset              synchronous active-high; clears the read registers only
//   we_a/we_b          write enables
//   re_a/re_b          read enables; read registers hold when low
//   addr_a/addr_b      word addresses (shared by read and write of a port)
//   wdata_a/wdata_b    write data
//   rdata_a/rdata_b    registered read data
// ---------------------------------------------------------------------------
module dmem_bank #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              we_a,
    input  logic              re_a,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [DATA_W-1:0] wdata_a,
    input  logic              we_b,
    input  logic              re_b,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] wdata_b,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic              we_a_eff;

    // Younger slot wins a same-word double write: drop A's write.
    assign we_a_eff = we_a && !(we_b && (addr_a == addr_b));

    // NOTE: the array has no reset; clearing thousands of words in one edge
    // would not map to RAM. The owner zeroes it with a sweep instead.
    always_ff @(posedge clock) begin
        if (we_a_eff) mem[addr_a] <= wdata_a;
        if (we_b)     mem[addr_b] <= wdata_b;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rdata_a <= '0;
            rdata_b <= '0;
        end else begin
            if (re_a) rdata_a <= mem[addr_a];
            if (re_b) rdata_b <= mem[addr_b];
        end
    end

endmodule

// File: rtl/dual_dmem_responder.sv
// ---------------------------------------------------------------------------
// dual_dmem_responder
// Responder side of a 2-wide core's data-memory interface. Slot A is the older
// instruction, slot B the younger. One request per slot per cycle, read data
// one cycle later. After reset the whole array is swept to zero (ready=0)
// before requests are accepted.
// Ports:
//   clock, reset            rising-edge clock, synchronous active-high reset
//   ready                   high once the zeroing sweep has finished
//   address_x, data_x       slot x word address and store data
//   wren_x, rden_x          slot x write / read enables
//   q_x, q_valid_x          slot x read data and its valid flag
//   conflict                pulse: previous accepted cycle had an A/B
//                           same-address hazard
// Optional (macro DMEM_STATS_EN):
//   stat_reads, stat_writes, stat_conflicts   32-bit saturating counters
// ---------------------------------------------------------------------------
module dual_dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT,
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic              clock,
    input  logic              reset,
    output logic              ready,
    input  logic [ADDR_W-1:0] address_a,
    input  logic [DATA_W-1:0] data_a,
    input  logic              wren_a,
    input  logic              rden_a,
    output logic [DATA_W-1:0] q_a,
    output logic              q_valid_a,
    input  logic [ADDR_W-1:0] address_b,
    input  logic [DATA_W-1:0] data_b,
    input  logic              wren_b,
    input  logic              rden_b,
    output logic [DATA_W-1:0] q_b,
    output logic              q_valid_b,
    output logic              conflict
`ifdef DMEM_STATS_EN
    ,
    output logic [31:0]       stat_reads,
    output logic [31:0]       stat_writes,
    output logic [31:0]       stat_conflicts
`endif
);

    state_t            state;
    logic [ADDR_W-1:0] sweep_ptr;

    logic              run;
    logic              acc_a, acc_b;
    hazard_t           hazard;

    // Forwarding path: when set, q_x comes from fwd_data_x instead of the bank.
    logic              fwd_sel_a, fwd_sel_b;
    logic [DATA_W-1:0] fwd_data_a, fwd_data_b;

    logic              bank_we_a, bank_re_a, bank_we_b, bank_re_b;
    logic [ADDR_W-1:0] bank_addr_a;
    logic [DATA_W-1:0] bank_wdata_a;
    logic [DATA_W-1:0] bank_rdata_a, bank_rdata_b;

    assign run    = (state == RUN);
    assign acc_a  = run && (rden_a || wren_a);
    assign acc_b  = run && (rden_b || wren_b);
    assign hazard = classify_hazard(address_a == address_b, acc_a, acc_b,
                                    wren_a, wren_b);

    // Port A doubles as the sweep write port during INIT. Nothing reaches
    // the array on a reset edge.
    // NOTE: every output of this block gets a default first so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        bank_we_a    = 1'b0;
        bank_re_a    = 1'b0;
        bank_addr_a  = address_a;
        bank_wdata_a = data_a;
        bank_we_b    = 1'b0;
        bank_re_b    = 1'b0;
        if (!reset) begin
            if (state == INIT) begin
                bank_we_a    = 1'b1;
                bank_addr_a  = sweep_ptr;
                bank_wdata_a = '0;
            end else begin
                bank_we_a = wren_a;
                bank_re_a = rden_a;
                bank_we_b = wren_b;
                bank_re_b = rden_b;
            end
        end
    end

    dmem_bank #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_bank (
        .clock   (clock),
        .reset   (reset),
        .we_a    (bank_we_a),
        .re_a    (bank_re_a),
        .addr_a  (bank_addr_a),
        .wdata_a (bank_wdata_a),
        .we_b    (bank_we_b),
        .re_b    (bank_re_b),
        .addr_b  (address_b),
        .wdata_b (data_b),
        .rdata_a (bank_rdata_a),
        .rdata_b (bank_rdata_b)
    );

    // Both selector and sources are registers updated only on accepted reads,
    // so q_x holds its value while q_valid_x is low.
    assign q_a = fwd_sel_a ? fwd_data_a : bank_rdata_a;
    assign q_b = fwd_sel_b ? fwd_data_b : bank_rdata_b;

    // NOTE: all state below is sequential and uses non-blocking assignments so
    // every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= INIT;
            sweep_ptr  <= '0;
            ready      <= 1'b0;
            q_valid_a  <= 1'b0;
            q_valid_b  <= 1'b0;
            conflict   <= 1'b0;
            fwd_sel_a  <= 1'b0;
            fwd_sel_b  <= 1'b0;
            fwd_data_a <= '0;
            fwd_data_b <= '0;
        end else begin
            case (state)
                INIT: begin
                    q_valid_a <= 1'b0;
                    q_valid_b <= 1'b0;
                    conflict  <= 1'b0;
                    sweep_ptr <= sweep_ptr + ADDR_W'(1);
                    if (sweep_ptr == '1) begin
                        state <= RUN;
                        ready <= 1'b1;
                    end
                end
                RUN: begin
                    ready     <= 1'b1;
                    q_valid_a <= acc_a && rden_a;
                    q_valid_b <= acc_b && rden_b;
                    conflict  <= (hazard != NONE);
                    if (acc_a && rden_a) begin
                        // Own store is returned; otherwise the old contents.
                        fwd_sel_a  <= wren_a;
                        fwd_data_a <= data_a;
                    end
                    if (acc_b && rden_b) begin
                        if (wren_b) begin
                            fwd_sel_b  <= 1'b1;
                            fwd_data_b <= data_b;
                        end else if (hazard == WR_FWD) begin
                            fwd_sel_b  <= 1'b1;
                            fwd_data_b <= data_a;
                        end else begin
                            fwd_sel_b  <= 1'b0;
                        end
                    end
                end
                default: state <= INIT;
            endcase
        end
    end

`ifdef DMEM_STATS_EN
    function automatic logic [31:0] sat_add(input logic [31:0] cnt,
                                            input logic [1:0]  inc);
        logic [32:0] sum;
        sum = {1'b0, cnt} + {31'b0, inc};
        return sum[32] ? '1 : sum[31:0];
    endfunction

    logic [1:0] read_inc, write_inc, conf_inc;

    assign read_inc  = {1'b0, acc_a && rden_a} + {1'b0, acc_b && rden_b};
    assign write_inc = {1'b0, acc_a && wren_a} + {1'b0, acc_b && wren_b};
    // Counted on the edge that raises the conflict pulse.
    assign conf_inc  = {1'b0, hazard != NONE};

    always_ff @(posedge clock) begin
        if (reset) begin
            stat_reads     <= '0;
            stat_writes    <= '0;
            stat_conflicts <= '0;
        end else begin
            stat_reads     <= sat_add(stat_reads, read_inc);
            stat_writes    <= sat_add(stat_writes, write_inc);
            stat_conflicts <= sat_add(stat_conflicts, conf_inc);
        end
    end
`endif

endmodule

// File: tb/tb_dual_dmem_responder.sv
// ---------------------------------------------------------------------------
// tb_dual_dmem_responder
// Directed bench for dual_dmem_responder built with ADDR_W=4 (16 words).
// Expected read data is pushed to per-slot queues as requests are driven and
// popped when the responder returns data one cycle later.
// ---------------------------------------------------------------------------
module tb_dual_dmem_responder;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 2 ** ADDR_W;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              ready;
    logic [ADDR_W-1:0] address_a = '0, address_b = '0;
    logic [DATA_W-1:0] data_a = '0, data_b = '0;
    logic              wren_a = 1'b0, rden_a = 1'b0;
    logic              wren_b = 1'b0, rden_b = 1'b0;
    logic [DATA_W-1:0] q_a, q_b;
    logic              q_valid_a, q_valid_b;
    logic              conflict;
`ifdef DMEM_STATS_EN
    logic [31:0]       stat_reads, stat_writes, stat_conflicts;
    int unsigned       m_reads = 0, m_writes = 0, m_conf = 0;
`endif

    dual_dmem_responder #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .ready     (ready),
        .address_a (address_a),
        .data_a    (data_a),
        .wren_a    (wren_a),
        .rden_a    (rden_a),
        .q_a       (q_a),
        .q_valid_a (q_valid_a),
        .address_b (address_b),
        .data_b    (data_b),
        .wren_b    (wren_b),
        .rden_b    (rden_b),
        .q_b       (q_b),
        .q_valid_b (q_valid_b),
        .conflict  (conflict)
`ifdef DMEM_STATS_EN
        ,
        .stat_reads     (stat_reads),
        .stat_writes    (stat_writes),
        .stat_conflicts (stat_conflicts)
`endif
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    logic [DATA_W-1:0] model [DEPTH];
    logic [DATA_W-1:0] exp_a_q [$];
    logic [DATA_W-1:0] exp_b_q [$];
    logic [DATA_W-1:0] last_qa, last_qb;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        wren_a = 1'b0; rden_a = 1'b0; address_a = '0; data_a = '0;
        wren_b = 1'b0; rden_b = 1'b0; address_b = '0; data_b = '0;
    endtask

    // Reset edge, then release. Model memory is zero after the sweep.
    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        check("rst_ready", ready, 0);
        check("rst_q_a", q_a, 0);
        check("rst_q_b", q_b, 0);
        check("rst_qv_a", q_valid_a, 0);
        check("rst_qv_b", q_valid_b, 0);
        check("rst_conflict", conflict, 0);
        foreach (model[i]) model[i] = '0;
        last_qa = '0;
        last_qb = '0;
`ifdef DMEM_STATS_EN
        m_reads = 0; m_writes = 0; m_conf = 0;
`endif
        @(negedge clock);
        reset = 1'b0;
    endtask

    // Counts edges after the reset edge until ready rises (bounded).
    task automatic wait_ready(output int n);
        n = 0;
        while (ready !== 1'b1 && n < 100) begin
            @(posedge clock);
            #1;
            n++;
        end
    endtask

    // One RUN-state cycle: drive both slots, predict, then check after the edge.
    task automatic step(input logic wa, input logic ra,
                        input logic [ADDR_W-1:0] aa, input logic [31:0] da,
                        input logic wb, input logic rb,
                        input logic [ADDR_W-1:0] ab, input logic [31:0] db);
        bit   pa, pb;
        logic exp_conf;
        logic [31:0] e;
        @(negedge clock);
        wren_a = wa; rden_a = ra; address_a = aa; data_a = da;
        wren_b = wb; rden_b = rb; address_b = ab; data_b = db;
        pa = ra;
        pb = rb;
        exp_conf = (wa || ra) && (wb || rb) && (aa == ab);
        if (ra) exp_a_q.push_back(wa ? da : model[aa]);
        if (rb) exp_b_q.push_back(wb ? db : ((wa && aa == ab) ? da : model[ab]));
        if (wa) model[aa] = da;
        if (wb) model[ab] = db;
`ifdef DMEM_STATS_EN
        m_reads  += int'(ra) + int'(rb);
        m_writes += int'(wa) + int'(wb);
        m_conf   += int'(exp_conf);
`endif
        @(posedge clock);
        #1;
        check("ready_run", ready, 1);
        check("q_valid_a", q_valid_a, pa);
        check("q_valid_b", q_valid_b, pb);
        check("conflict", conflict, exp_conf);
        if (pa) begin
            e = exp_a_q.pop_front();
            check("q_a", q_a, e);
            last_qa = e;
        end else begin
            check("q_a_hold", q_a, last_qa);
        end
        if (pb) begin
            e = exp_b_q.pop_front();
            check("q_b", q_b, e);
            last_qb = e;
        end else begin
            check("q_b_hold", q_b, last_qb);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        clear_inputs();

        // Reset and sweep length.
        do_reset();
        wait_ready(n);
        check("init_cycles", n, DEPTH);

        // Fresh memory reads zero on both slots.
        step(0, 1, 4'd9, 0, 0, 1, 4'd0, 0);
        step(0, 1, 4'd15, 0, 0, 1, 4'd15, 0);

        // Write then read next cycle on the other slot, no hazard.
        step(1, 0, 4'd3, 32'hDEADBEEF, 0, 0, 4'd0, 0);
        step(0, 0, 4'd0, 0, 0, 1, 4'd3, 0);

        // Double write to the same word: B wins, conflict pulses.
        step(1, 0, 4'd5, 32'h11, 1, 0, 4'd5, 32'h22);
        step(0, 1, 4'd5, 0, 0, 0, 4'd0, 0);

        // A writes / B reads same word: B sees forwarded data.
        step(1, 0, 4'd7, 32'hAA, 0, 1, 4'd7, 0);
        // B writes / A reads same word: A sees the old contents.
        step(0, 1, 4'd7, 0, 1, 0, 4'd7, 32'hBB);
        // Both read: both see the stored word.
        step(0, 1, 4'd7, 0, 0, 1, 4'd7, 0);

        // Same-slot write+read returns the new data.
        step(1, 1, 4'd10, 32'h1234, 1, 1, 4'd11, 32'h5678);
        // Idle cycle: valids drop, data holds.
        step(0, 0, 4'd0, 0, 0, 0, 4'd0, 0);

        // Independent addresses.
        step(1, 0, 4'd1, 32'hCAFE0001, 1, 0, 4'd2, 32'hCAFE0002);
        step(0, 1, 4'd2, 0, 0, 1, 4'd1, 0);
        // A writes+reads, B reads same word: B gets A's data.
        step(1, 1, 4'd12, 32'h77, 0, 1, 4'd12, 0);

`ifdef DMEM_STATS_EN
        check("stat_reads", stat_reads, m_reads);
        check("stat_writes", stat_writes, m_writes);
        check("stat_conflicts", stat_conflicts, m_conf);
`endif

        // Reset mid-sweep with a write presented during INIT.
        do_reset();
        address_a = 4'd2; data_a = 32'h55; wren_a = 1'b1;
        repeat (8) @(posedge clock);
        #1;
        check("mid_init_ready", ready, 0);
        do_reset();
        wait_ready(n);
        check("reinit_cycles", n, DEPTH);
        @(negedge clock);
        clear_inputs();
        step(0, 1, 4'd2, 0, 0, 1, 4'd3, 0);
        step(0, 1, 4'd7, 0, 0, 1, 4'd5, 0);

`ifdef DMEM_STATS_EN
        check("stat_reads_after_reset", stat_reads, m_reads);
        check("stat_writes_after_reset", stat_writes, m_writes);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
